// File: rtl/mem_req_arbiter.sv
// Round-robin front end that maps lane load/store requests onto the two read
// ports and one write port of the shared data memory, routing responses back.
module mem_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ-1:0]     req_we,
  input  logic [NUM_REQ*16-1:0]  req_addr,
  input  logic [NUM_REQ*32-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic [NUM_REQ*32-1:0]  resp_data,
  output logic [15:0]            mem_read0,
  input  logic [31:0]            mem_out0,
  output logic [15:0]            mem_read1,
  input  logic [31:0]            mem_out1,
  output logic                   mem_writing,
  output logic [15:0]            mem_waddr,
  output logic [31:0]            mem_wdata
);

  logic [15:0] addr_a  [NUM_REQ];
  logic [31:0] wdata_a [NUM_REQ];
  logic [31:0] rdata_a [NUM_REQ];

  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_lane
      assign addr_a[g]              = req_addr[16*g +: 16];
      assign wdata_a[g]             = req_wdata[32*g +: 32];
      assign resp_data[32*g +: 32]  = rdata_a[g];
    end
  endgenerate

  logic [IDW-1:0]     rr_ptr, rr_next, idx;
  logic [IDW-1:0]     wr_id, rd0_id, rd1_id;
  logic               wr_found, rd0_found, rd1_found, any_grant;
  logic [NUM_REQ-1:0] grant;

  logic               p0_v, p1_v, pw_v;
  logic [IDW-1:0]     p0_id, p1_id, pw_id;

  // The write is picked first so reads that collide with it can be held back
  // one cycle and then observe the freshly written word.
  always_comb begin
    wr_found  = 1'b0;
    wr_id     = '0;
    rd0_found = 1'b0;
    rd0_id    = '0;
    rd1_found = 1'b0;
    rd1_id    = '0;
    grant     = '0;
    any_grant = 1'b0;
    rr_next   = rr_ptr;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IDW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!wr_found && req_valid[idx] && req_we[idx]) begin
        wr_found = 1'b1;
        wr_id    = idx;
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IDW'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_valid[idx] && !req_we[idx] && !(wr_found && addr_a[idx] == addr_a[wr_id])) begin
        if (!rd0_found) begin
          rd0_found = 1'b1;
          rd0_id    = idx;
        end else if (!rd1_found) begin
          rd1_found = 1'b1;
          rd1_id    = idx;
        end
      end
    end
    if (wr_found)  grant[wr_id]  = 1'b1;
    if (rd0_found) grant[rd0_id] = 1'b1;
    if (rd1_found) grant[rd1_id] = 1'b1;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IDW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!any_grant && grant[idx]) begin
        any_grant = 1'b1;
        rr_next   = IDW'((int'(idx) + 1) % NUM_REQ);
      end
    end
  end

  assign req_ready   = rst_n ? grant : '0;
  assign mem_read0   = (rst_n && rd0_found) ? addr_a[rd0_id] : 16'h0;
  assign mem_read1   = (rst_n && rd1_found) ? addr_a[rd1_id] : 16'h0;
  assign mem_writing = rst_n & wr_found;
  assign mem_waddr   = mem_writing ? addr_a[wr_id]  : 16'h0;
  assign mem_wdata   = mem_writing ? wdata_a[wr_id] : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      p0_v   <= 1'b0;
      p0_id  <= '0;
      p1_v   <= 1'b0;
      p1_id  <= '0;
      pw_v   <= 1'b0;
      pw_id  <= '0;
    end else begin
      rr_ptr <= rr_next;
      p0_v   <= rd0_found;
      p0_id  <= rd0_id;
      p1_v   <= rd1_found;
      p1_id  <= rd1_id;
      pw_v   <= wr_found;
      pw_id  <= wr_id;
    end
  end

  // Memory read data is already registered, so responses are a pure mux.
  always_comb begin
    resp_valid = '0;
    rdata_a    = '{default: '0};
    if (p0_v) begin
      resp_valid[p0_id] = 1'b1;
      rdata_a[p0_id]    = mem_out0;
    end
    if (p1_v) begin
      resp_valid[p1_id] = 1'b1;
      rdata_a[p1_id]    = mem_out1;
    end
    if (pw_v) begin
      resp_valid[pw_id] = 1'b1;
      rdata_a[pw_id]    = 32'h0;
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: fixed vectors, multi-cycle corner sequences and
// random traffic against a queue-based grant model with a shadow memory.
module tb_mem_req_arbiter;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid = '0, req_ready, req_we = '0;
  logic [N*16-1:0] req_addr = '0;
  logic [N*32-1:0] req_wdata = '0;
  logic [N-1:0]  resp_valid;
  logic [N*32-1:0] resp_data;
  logic [15:0]   mem_read0, mem_read1, mem_waddr;
  logic [31:0]   mem_out0, mem_out1, mem_wdata;
  logic          mem_writing;

  int tests = 0;
  int failed = 0;

  mem_req_arbiter #(.NUM_REQ(N), .IDW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .mem_read0(mem_read0), .mem_out0(mem_out0),
    .mem_read1(mem_read1), .mem_out1(mem_out1),
    .mem_writing(mem_writing), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(logic [15:0] a);
    if (a == 16'h0010) return 32'hDEADBEEF;
    return {a, ~a} ^ 32'h13572468;
  endfunction

  // Memory device: registered reads, old data on same-cycle read/write.
  logic [31:0] dmem [65536];
  bit          dwr  [65536];
  function automatic logic [31:0] dev_rd(logic [15:0] a);
    return dwr[a] ? dmem[a] : init_word(a);
  endfunction
  always @(posedge clk) begin
    mem_out0 <= dev_rd(mem_read0);
    mem_out1 <= dev_rd(mem_read1);
    if (mem_writing) begin
      dmem[mem_waddr] <= mem_wdata;
      dwr[mem_waddr]  <= 1'b1;
    end
  end

  logic [31:0] shmem [65536];
  bit          shwr  [65536];
  function automatic logic [31:0] sh_rd(logic [15:0] a);
    return shwr[a] ? shmem[a] : init_word(a);
  endfunction

  logic [N-1:0]    exp_rv = '0;
  logic [N*32-1:0] exp_rd = '0;
  int              m_rr = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cycle(input string nm, input logic [3:0] v, input logic [3:0] we,
                       input logic [63:0] a, input logic [127:0] d, input logic [3:0] er,
                       input logic [15:0] e0, input logic [15:0] e1, input logic ew,
                       input logic [15:0] ewa, input logic [31:0] ewd);
    @(posedge clk); #1;
    req_valid = v; req_we = we; req_addr = a; req_wdata = d;
    @(negedge clk);
    chk({nm, "_resp_valid"}, resp_valid, exp_rv);
    chk({nm, "_resp_data"}, resp_data, exp_rd);
    chk({nm, "_ready"}, req_ready, er);
    chk({nm, "_read0"}, mem_read0, e0);
    chk({nm, "_read1"}, mem_read1, e1);
    chk({nm, "_writing"}, mem_writing, ew);
    chk({nm, "_waddr"}, mem_waddr, ewa);
    chk({nm, "_wdata"}, mem_wdata, ewd);
    exp_rv = er;
    exp_rd = '0;
    for (int l = 0; l < N; l++)
      if (er[l] && !we[l]) exp_rd[32*l +: 32] = sh_rd(a[16*l +: 16]);
    if (ew) begin
      shmem[ewa] = ewd;
      shwr[ewa]  = 1'b1;
    end
  endtask

  task automatic idle();
    cycle("idle", 4'h0, 4'h0, 64'h0, 128'h0, 4'h0, 16'h0, 16'h0, 1'b0, 16'h0, 32'h0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    req_valid = 4'hF; req_we = 4'b1010;
    req_addr = {4{16'h0AAA}}; req_wdata = {4{32'h5EED5EED}};
    #1;
    chk("rst_ready", req_ready, 4'h0);
    chk("rst_read0", mem_read0, 16'h0);
    chk("rst_read1", mem_read1, 16'h0);
    chk("rst_writing", mem_writing, 1'b0);
    chk("rst_waddr", mem_waddr, 16'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_resp_valid", resp_valid, 4'h0);
    chk("rst_resp_data", resp_data, 128'h0);
    exp_rv = '0; exp_rd = '0; m_rr = 0;
    @(posedge clk); #1;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Reference grant: walk lanes in round-robin order as a list and pick by rule.
  task automatic model_grant(input logic [3:0] v, input logic [3:0] we, input logic [63:0] a,
                             input logic [127:0] d, output logic [3:0] rdy,
                             output logic [15:0] r0, output logic [15:0] r1, output logic w,
                             output logic [15:0] wa, output logic [31:0] wdv);
    int order[$];
    int reads[$];
    int wl;
    bit moved;
    rdy = '0; r0 = '0; r1 = '0; w = 1'b0; wa = '0; wdv = '0; wl = -1; moved = 0;
    for (int k = 0; k < N; k++) order.push_back((m_rr + k) % N);
    foreach (order[j]) if (wl < 0 && v[order[j]] && we[order[j]]) wl = order[j];
    foreach (order[j]) begin
      int l;
      l = order[j];
      if (v[l] && !we[l] && reads.size() < 2) begin
        if (wl < 0) reads.push_back(l);
        else if (a[16*l +: 16] != a[16*wl +: 16]) reads.push_back(l);
      end
    end
    if (wl >= 0) begin
      w = 1'b1; wa = a[16*wl +: 16]; wdv = d[32*wl +: 32]; rdy[wl] = 1'b1;
    end
    if (reads.size() > 0) begin r0 = a[16*reads[0] +: 16]; rdy[reads[0]] = 1'b1; end
    if (reads.size() > 1) begin r1 = a[16*reads[1] +: 16]; rdy[reads[1]] = 1'b1; end
    foreach (order[j]) if (!moved && rdy[order[j]]) begin
      m_rr = (order[j] + 1) % N;
      moved = 1;
    end
  endtask

  typedef struct {
    logic [3:0]   v, we;
    logic [63:0]  a;
    logic [127:0] d;
    logic [3:0]   er;
    logic [15:0]  e0, e1;
    logic         ew;
    logic [15:0]  ewa;
    logic [31:0]  ewd;
  } vec_t;

  vec_t tab [9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]   pv, pwe, er;
    logic [63:0]  pa;
    logic [127:0] pd;
    logic [15:0]  e0, e1, ewa;
    logic         ew;
    logic [31:0]  ewd;

    tab[0] = '{4'h0, 4'h0, 64'h0, 128'h0, 4'h0, 16'h0, 16'h0, 1'b0, 16'h0, 32'h0};
    tab[1] = '{4'b0010, 4'h0, {16'h0, 16'h0, 16'h0010, 16'h0}, 128'h0,
               4'b0010, 16'h0010, 16'h0, 1'b0, 16'h0, 32'h0};
    tab[2] = '{4'b0101, 4'h0, {16'h0, 16'h0002, 16'h0, 16'h0001}, 128'h0,
               4'b0101, 16'h0001, 16'h0002, 1'b0, 16'h0, 32'h0};
    tab[3] = '{4'b1111, 4'h0, {16'h0023, 16'h0022, 16'h0021, 16'h0020}, 128'h0,
               4'b0011, 16'h0020, 16'h0021, 1'b0, 16'h0, 32'h0};
    tab[4] = '{4'b1001, 4'b1000, {16'h00B0, 16'h0, 16'h0, 16'h00B0}, {32'h55AA55AA, 96'h0},
               4'b1000, 16'h0, 16'h0, 1'b1, 16'h00B0, 32'h55AA55AA};
    tab[5] = '{4'b0110, 4'b0110, {16'h0, 16'h0031, 16'h0030, 16'h0}, {32'h0, 32'h2, 32'h1, 32'h0},
               4'b0010, 16'h0, 16'h0, 1'b1, 16'h0030, 32'h1};
    tab[6] = '{4'b1111, 4'b0001, {16'h0042, 16'h0040, 16'h0041, 16'h0040}, {96'h0, 32'h0000CAFE},
               4'b1011, 16'h0041, 16'h0042, 1'b1, 16'h0040, 32'h0000CAFE};
    tab[7] = '{4'b1100, 4'h0, {16'h0050, 16'h0050, 16'h0, 16'h0}, 128'h0,
               4'b1100, 16'h0050, 16'h0050, 1'b0, 16'h0, 32'h0};
    tab[8] = '{4'b1110, 4'b0110, {16'h0030, 16'h0031, 16'h0030, 16'h0}, {32'h0, 32'h2, 32'h1, 32'h0},
               4'b0010, 16'h0, 16'h0, 1'b1, 16'h0030, 32'h1};

    repeat (3) @(posedge clk);

    for (int i = 0; i < 9; i++) begin
      do_reset();
      cycle($sformatf("tab%0d", i), tab[i].v, tab[i].we, tab[i].a, tab[i].d, tab[i].er,
            tab[i].e0, tab[i].e1, tab[i].ew, tab[i].ewa, tab[i].ewd);
      idle();
    end

    // All four lanes read: two per cycle, pointer moves past lane 0.
    do_reset();
    cycle("s1a", 4'b1111, 4'h0, {16'h0063, 16'h0062, 16'h0061, 16'h0060}, 128'h0,
          4'b0011, 16'h0060, 16'h0061, 1'b0, 16'h0, 32'h0);
    cycle("s1b", 4'b1100, 4'h0, {16'h0063, 16'h0062, 16'h0061, 16'h0060}, 128'h0,
          4'b1100, 16'h0062, 16'h0063, 1'b0, 16'h0, 32'h0);
    idle();

    // Read/write hazard: the read waits a cycle and sees the new word.
    do_reset();
    cycle("s2a", 4'b1001, 4'b1000, {16'h00AA, 16'h0, 16'h0, 16'h00AA}, {32'h12345678, 96'h0},
          4'b1000, 16'h0, 16'h0, 1'b1, 16'h00AA, 32'h12345678);
    cycle("s2b", 4'b0001, 4'h0, {48'h0, 16'h00AA}, 128'h0,
          4'b0001, 16'h00AA, 16'h0, 1'b0, 16'h0, 32'h0);
    idle();

    // Two writers serialise on the single write port.
    do_reset();
    cycle("s3a", 4'b0110, 4'b0110, {16'h0, 16'h0032, 16'h0031, 16'h0}, {32'h0, 32'h22, 32'h11, 32'h0},
          4'b0010, 16'h0, 16'h0, 1'b1, 16'h0031, 32'h11);
    cycle("s3b", 4'b0100, 4'b0100, {16'h0, 16'h0032, 16'h0031, 16'h0}, {32'h0, 32'h22, 32'h11, 32'h0},
          4'b0100, 16'h0, 16'h0, 1'b1, 16'h0032, 32'h22);
    idle();

    // Reset in the response cycle drops the response and the pointer.
    do_reset();
    cycle("s4a", 4'b0010, 4'h0, {16'h0, 16'h0, 16'h0010, 16'h0}, 128'h0,
          4'b0010, 16'h0010, 16'h0, 1'b0, 16'h0, 32'h0);
    @(posedge clk); #1;
    req_valid = '0;
    chk("s4_resp_live", resp_valid, 4'b0010);
    rst_n = 1'b0;
    req_valid = 4'b1000; req_we = 4'b1000;
    req_addr = {16'h00C0, 48'h0}; req_wdata = {32'h77, 96'h0};
    #1;
    chk("s4_resp_valid_drop", resp_valid, 4'h0);
    chk("s4_resp_data_drop", resp_data, 128'h0);
    chk("s4_writing_rst", mem_writing, 1'b0);
    chk("s4_ready_rst", req_ready, 4'h0);
    exp_rv = '0; exp_rd = '0; m_rr = 0;
    @(negedge clk);
    chk("s4_writing_rst2", mem_writing, 1'b0);
    chk("s4_waddr_rst2", mem_waddr, 16'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    rst_n = 1'b1;
    idle();
    cycle("s4c", 4'b1111, 4'h0, {16'h0073, 16'h0072, 16'h0071, 16'h0070}, 128'h0,
          4'b0011, 16'h0070, 16'h0071, 1'b0, 16'h0, 32'h0);
    cycle("s4d", 4'b1100, 4'h0, {16'h0073, 16'h0072, 16'h0071, 16'h0070}, 128'h0,
          4'b1100, 16'h0072, 16'h0073, 1'b0, 16'h0, 32'h0);
    idle();

    // Random traffic: lanes hold requests until accepted, narrow address range.
    do_reset();
    pv = '0; pwe = '0; pa = '0; pd = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int l = 0; l < N; l++) begin
        if (!pv[l] && $urandom_range(0, 2) != 0) begin
          pv[l] = 1'b1;
          pwe[l] = ($urandom_range(0, 2) == 0);
          pa[16*l +: 16] = 16'($urandom_range(0, 7));
          pd[32*l +: 32] = $urandom;
        end
      end
      model_grant(pv, pwe, pa, pd, er, e0, e1, ew, ewa, ewd);
      cycle("rnd", pv, pwe, pa, pd, er, e0, e1, ew, ewa, ewd);
      pv = pv & ~er;
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Initiator-side front end for the shared 64K x 32 data memory (2 synchronous read ports, 1 write port, 1-cycle registered read latency).
- Arbitrates load/store requests from NUM_REQ GPU lane load-store units onto the memory's read0/read1/write ports.
- Returns read data and write acks to the requester that issued them, one cycle after acceptance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
IDW, 2, requester index width, ceil(log2(NUM_REQ))

Ports:
clk  in  1  clock, all state on posedge
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester request accepted this cycle
req_we  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*16  word address, requester i at [16i+15:16i]
req_wdata  in  NUM_REQ*32  write data, requester i at [32i+31:32i]
resp_valid  out  NUM_REQ  response pulse for requester i
resp_data  out  NUM_REQ*32  read data for requester i; 0 for write acks
mem_read0  out  16  memory read port 0 address
mem_out0  in  32  memory read port 0 data (registered in memory)
mem_read1  out  16  memory read port 1 address
mem_out1  in  32  memory read port 1 data
mem_writing  out  1  memory write enable
mem_waddr  out  16  memory write address
mem_wdata  out  32  memory write data

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Handshake: a request transfers when req_valid[i] & req_ready[i].
  - A requester holds valid, we, addr and wdata stable until accepted.
  - req_ready is combinational from the current inputs and arbiter state.
- Grant per cycle, scanning requesters from rr_ptr upward with wrap-around:
  - the first two valid reads are granted; the first goes to port 0, the second to port 1;
  - the first valid write is granted to the write port;
  - all other requesters see req_ready = 0.
- Memory drive is combinational in the grant cycle:
  - mem_read0 / mem_read1 = granted read addresses, 0 when a port is unused;
  - mem_writing = 1 only when a write is granted; mem_waddr and mem_wdata come from that write, otherwise 0.
- Read/write hazard: a read whose address equals the address of the write granted in the same cycle is not granted.
  - It retries next cycle and then returns the newly written data. The memory returns old data on same-cycle read/write.
  - Two reads to the same address in one cycle are both granted.
- Pipeline register (reset 0): valid bit plus IDW-bit requester id for port 0, port 1 and the write.
- Response, in the cycle after acceptance:
  - resp_valid[id] = 1 for exactly one cycle;
  - resp_data[id] = mem_out0 or mem_out1 for reads, according to the port used; 0 for write acks;
  - non-responding lanes have resp_data = 0.
  - One cycle carries at most 3 responses, always to distinct requesters.
- Latency and throughput:
  - request-to-response latency is exactly 1 cycle;
  - a requester may issue a new request in its response cycle;
  - peak throughput is 2 reads + 1 write per cycle.
- rr_ptr (IDW bits, reset 0):
  - on any grant, advances to (lowest-scan-order granted index + 1) mod NUM_REQ;
  - unchanged when nothing is granted.
- Reset (asynchronous, any time, including mid-operation):
  - pipeline valids, rr_ptr, resp_valid and resp_data clear immediately;
  - while rst_n = 0: req_ready = 0, mem_writing = 0, all mem address/data outputs = 0;
  - in-flight responses are dropped.
- Idle (no req_valid): all outputs 0.

Test Plan:
- Reset, then lane 1 reads 0x0010 (mem holds 0xDEADBEEF) -> req_ready[1]=1 and mem_read0=0x0010 in cycle 0; resp_valid[1]=1, resp_data[1]=0xDEADBEEF in cycle 1; no other resp_valid.
- Lanes 0 and 2 read 0x0001 and 0x0002 together -> both ready in the same cycle; lane 0 on port 0, lane 2 on port 1; both responses next cycle with the correct data.
- Lanes 0,1,2,3 all read with rr_ptr=0 -> cycle 0 grants 0,1 and rr_ptr becomes 1; cycle 1 grants 2,3; 4 responses total, each lane exactly once.
- Lane 3 writes 0x00AA=0x12345678 while lane 0 reads 0x00AA in the same cycle -> write granted with mem_writing=1; lane 0 ready=0; lane 0 granted next cycle; resp_data[0]=0x12345678; lane 3 gets ack with data 0.
- Lanes 1 and 2 both write -> only lane 1 granted in cycle 0, lane 2 in cycle 1; mem_writing high both cycles.
- Assert rst_n=0 in the cycle after a read grant -> resp_valid drops to 0 immediately and no response is ever delivered; mem_writing=0 throughout reset; after release, rr_ptr=0.
